operand_stream_feeder: RTL and testbench
========================================

// Module: operand_stream_feeder
// PURPOSE
// - Transmit side of the tile's 48-bit operand bus: reads sparse weight and activation entries (value + 16b index)
//   from two synchronous SRAMs and drives ram_data words into the bitfuscnn tile.
// - Walks activation groups (outer) x weight groups (inner), 4 lanes/group; valid/ready flow control;
//   done strobes mark the end of each weight pass and of the whole channel group.
// PARAMETERS
// - RAM_WIDTH   14  SRAM address width
// - WCOUNT_W     4  width of weight_count
// - ACOUNT_W     8  width of activation_count
// - LANES        4  entries per group (fixed 4; the tile FIFO depth)
// PORTS
// - clk              in   1          clock, all logic rising edge
// - reset_n          in   1          reset, asynchronous, active-low
// - start            in   1          1-cycle pulse, begin channel group; ignored unless IDLE
// - weight_count     in   WCOUNT_W   non-zero weight entries; sampled on start
// - activation_count in   ACOUNT_W   non-zero activation entries; sampled on start
// - weight_base      in   RAM_WIDTH  weight SRAM base address; sampled on start
// - act_base         in   RAM_WIDTH  activation SRAM base address; sampled on start
// - wram_en/aram_en  out  1          SRAM read enables
// - wram_addr/aram_addr out RAM_WIDTH SRAM read addresses
// - wram_rdata/aram_rdata in 24      {index[23:8], value[7:0]}, valid 1 cycle after en
// - ram_data         out  48         {act_idx[47:32], act[31:24], w_idx[23:8], w[7:0]}
// - ram_valid        out  1          ram_data valid
// - ram_ready        in   1          tile accepts word when valid&ready
// - weight_done      out  1          1-cycle pulse: last word of a weight pass accepted
// - activation_done  out  1          1-cycle pulse: last word of channel group accepted
// - busy             out  1          high from start to activation_done
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0, skid buffer empty; reset mid-run aborts silently (no done strobes).
// - FSM: IDLE -start-> RUN; RUN -last read issued-> DRAIN; DRAIN -last word accepted-> IDLE.
//   Zero weight_count or activation_count: IDLE -start-> IDLE with activation_done+weight_done pulsed next cycle, no words.
// - Word k of a group (lane k=0..3) pairs weight[wg*4+k] with activation[ag*4+k]; addr = base + grp*4 + k.
//   Lane beyond count in final group: no SRAM read for that side, field driven 0 (value 0, index 0).
// - Order: for ag in 0..ceil(A/4)-1: for wg in 0..ceil(W/4)-1: lanes 0..3. Total words = 4*ceil(A/4)*ceil(W/4).
// - Reads issued only if (skid occupancy + reads in flight) < 2; both SRAMs always read in lockstep.
// - Latency: start sampled edge E0 -> first en in cycle after E0 -> ram_valid high after E2 (ready held high).
// - Throughput: 1 word/cycle with ram_ready high; ram_ready low holds ram_data/ram_valid stable (AXI-style, no drop).
// - weight_done pulses on acceptance of lane 3 of last wg of each ag; activation_done with weight_done on final word.
// - start while busy ignored; count/base inputs changing while busy have no effect.
// - Address arithmetic wraps mod 2^RAM_WIDTH; no error flagged.
// STRUCTURE
// - Package bitfuscnn_pkg: operand_word_t packed struct (48b layout above), sram_entry_t (24b), LANES=4,
//   feeder_state_e {IDLE,RUN,DRAIN}.
// - One sub-module: stream_skid_buffer (2-entry, 48b, valid/ready, push from SRAM return, pop to tile).
// - Top: FSM, group/lane counters, credit counter, done-strobe tagging carried alongside each buffered word.
// TESTING
// - W=4,A=4, ready=1 -> exactly 4 words, ram_valid high after E2, weight_done & activation_done on word 4, busy falls next.
// - W=5,A=3 -> 8 words; words 5-8 w lanes 1-3 = 0; act lane 3 = 0 in every word; weight_done after words 8 only (1 ag).
// - W=4,A=8, ready toggling 1/0 each cycle -> 8 words, no duplicate/loss, ram_data stable while ready=0, 2 weight_done.
// - W=0,A=7 -> no wram/aram enables, no valid, weight_done+activation_done 1 cycle after start.
// - reset_n low in middle of A=8,W=8 run -> outputs 0 immediately, no done strobes; new start runs cleanly from word 0.
// - start pulsed while busy with different counts -> ignored; stream matches original counts.

Source files
------------

// File: rtl/bitfuscnn_pkg.sv
// Shared types for the bitfuscnn operand feed path: SRAM entry, 48b operand word,
// buffered word with end-of-pass tags, and the feeder FSM states.
package bitfuscnn_pkg;

  localparam int LANES = 4;

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  val;
  } sram_entry_t;

  typedef struct packed {
    logic [15:0] act_idx;
    logic [7:0]  act;
    logic [15:0] w_idx;
    logic [7:0]  w;
  } operand_word_t;

  typedef struct packed {
    logic          wdone;
    logic          adone;
    operand_word_t word;
  } feeder_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer between SRAM return and tile; data visible the cycle after push.
// Head entry holds stable while pop_rdy is low; a push into a full buffer is dropped (caller meters credits).
module stream_skid_buffer #(
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  output logic              pop_vld,
  output logic [DATA_W-1:0] pop_dat,
  input  logic              pop_rdy,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok;
  logic              pop;

  assign pop_vld   = (count_q != 2'd0);
  assign pop_dat   = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  always_comb begin
    push_ok  = push_vld && (count_q != 2'd2);
    pop      = pop_vld && pop_rdy;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/operand_stream_feeder.sv
// Streams paired weight/activation SRAM entries to the tile; first word valid two edges after start.
// ram_ready low stalls the stream without loss; SRAM reads are credit-limited to the 2-entry buffer.
module operand_stream_feeder
  import bitfuscnn_pkg::*;
#(
  parameter int RAM_WIDTH = 14,
  parameter int WCOUNT_W  = 4,
  parameter int ACOUNT_W  = 8,
  parameter int LANES     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WCOUNT_W-1:0]  weight_count,
  input  logic [ACOUNT_W-1:0]  activation_count,
  input  logic [RAM_WIDTH-1:0] weight_base,
  input  logic [RAM_WIDTH-1:0] act_base,
  output logic                 wram_en,
  output logic [RAM_WIDTH-1:0] wram_addr,
  input  logic [23:0]          wram_rdata,
  output logic                 aram_en,
  output logic [RAM_WIDTH-1:0] aram_addr,
  input  logic [23:0]          aram_rdata,
  output logic [47:0]          ram_data,
  output logic                 ram_valid,
  input  logic                 ram_ready,
  output logic                 weight_done,
  output logic                 activation_done,
  output logic                 busy
);

  localparam int LANE_W = $clog2(LANES);
  localparam int WG_W   = WCOUNT_W - LANE_W;
  localparam int AG_W   = ACOUNT_W - LANE_W;

  feeder_state_e        state_q, state_d;
  logic [WCOUNT_W-1:0]  wcount_q, wcount_d;
  logic [ACOUNT_W-1:0]  acount_q, acount_d;
  logic [RAM_WIDTH-1:0] wbase_q, wbase_d;
  logic [RAM_WIDTH-1:0] abase_q, abase_d;
  logic [WG_W-1:0]      wg_q, wg_d;
  logic [AG_W-1:0]      ag_q, ag_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 pend_q, pend_d;
  logic                 pend_w_q, pend_w_d;
  logic                 pend_a_q, pend_a_d;
  logic                 pend_wdone_q, pend_wdone_d;
  logic                 pend_adone_q, pend_adone_d;
  logic                 zdone_q, zdone_d;

  logic [WCOUNT_W-1:0]  w_off, wcount_m1;
  logic [ACOUNT_W-1:0]  a_off, acount_m1;
  logic                 w_lane_ok, a_lane_ok;
  logic                 w_last_lane, a_last_grp;
  logic [1:0]           occupancy;
  logic [2:0]           used_slots;
  logic                 issue, pop, head_vld;
  feeder_entry_t        head, push_ent;
  sram_entry_t          w_ret, a_ret;

  assign w_off     = {wg_q, lane_q};
  assign a_off     = {ag_q, lane_q};
  assign wcount_m1 = wcount_q - 1'b1;
  assign acount_m1 = acount_q - 1'b1;
  assign w_lane_ok = (w_off < wcount_q);
  assign a_lane_ok = (a_off < acount_q);
  // Last-group tests use (count-1)/4, valid because RUN is only entered with non-zero counts.
  assign w_last_lane = (lane_q == LANE_W'(LANES - 1)) && (wg_q == wcount_m1[WCOUNT_W-1:LANE_W]);
  assign a_last_grp  = (ag_q == acount_m1[ACOUNT_W-1:LANE_W]);

  // A word popped this cycle frees its slot in time for a read issued now.
  assign pop        = head_vld && ram_ready;
  assign used_slots = {1'b0, occupancy} + {2'b0, pend_q} - {2'b0, pop};
  assign issue      = (state_q == RUN) && (used_slots < 3'd2);

  assign wram_en   = issue && w_lane_ok;
  assign aram_en   = issue && a_lane_ok;
  assign wram_addr = wbase_q + RAM_WIDTH'(w_off);
  assign aram_addr = abase_q + RAM_WIDTH'(a_off);

  assign w_ret = wram_rdata;
  assign a_ret = aram_rdata;

  always_comb begin
    push_ent       = '0;
    push_ent.wdone = pend_wdone_q;
    push_ent.adone = pend_adone_q;
    if (pend_w_q) begin
      push_ent.word.w_idx = w_ret.idx;
      push_ent.word.w     = w_ret.val;
    end
    if (pend_a_q) begin
      push_ent.word.act_idx = a_ret.idx;
      push_ent.word.act     = a_ret.val;
    end
  end

  stream_skid_buffer #(
    .DATA_W($bits(feeder_entry_t))
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (pend_q),
    .push_dat (push_ent),
    .pop_vld  (head_vld),
    .pop_dat  (head),
    .pop_rdy  (ram_ready),
    .occupancy(occupancy)
  );

  assign ram_data        = head.word;
  assign ram_valid       = head_vld;
  assign weight_done     = (pop && head.wdone) || zdone_q;
  assign activation_done = (pop && head.adone) || zdone_q;
  assign busy            = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    wcount_d     = wcount_q;
    acount_d     = acount_q;
    wbase_d      = wbase_q;
    abase_d      = abase_q;
    wg_d         = wg_q;
    ag_d         = ag_q;
    lane_d       = lane_q;
    zdone_d      = 1'b0;
    pend_d       = issue;
    pend_w_d     = wram_en;
    pend_a_d     = aram_en;
    pend_wdone_d = issue && w_last_lane;
    pend_adone_d = issue && w_last_lane && a_last_grp;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wcount_d = weight_count;
          acount_d = activation_count;
          wbase_d  = weight_base;
          abase_d  = act_base;
          wg_d     = '0;
          ag_d     = '0;
          lane_d   = '0;
          if ((weight_count == '0) || (activation_count == '0)) begin
            zdone_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          lane_d = lane_q + 1'b1;
          if (w_last_lane) begin
            wg_d = '0;
            if (a_last_grp) begin
              state_d = DRAIN;
            end else begin
              ag_d = ag_q + 1'b1;
            end
          end else if (lane_q == LANE_W'(LANES - 1)) begin
            wg_d = wg_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && head.adone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wcount_q     <= '0;
      acount_q     <= '0;
      wbase_q      <= '0;
      abase_q      <= '0;
      wg_q         <= '0;
      ag_q         <= '0;
      lane_q       <= '0;
      pend_q       <= 1'b0;
      pend_w_q     <= 1'b0;
      pend_a_q     <= 1'b0;
      pend_wdone_q <= 1'b0;
      pend_adone_q <= 1'b0;
      zdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcount_q     <= wcount_d;
      acount_q     <= acount_d;
      wbase_q      <= wbase_d;
      abase_q      <= abase_d;
      wg_q         <= wg_d;
      ag_q         <= ag_d;
      lane_q       <= lane_d;
      pend_q       <= pend_d;
      pend_w_q     <= pend_w_d;
      pend_a_q     <= pend_a_d;
      pend_wdone_q <= pend_wdone_d;
      pend_adone_q <= pend_adone_d;
      zdone_q      <= zdone_d;
    end
  end

endmodule

// File: tb/tb_operand_stream_feeder.sv
// Scoreboard bench: a loop-nest reference model queues expected words, a negedge monitor checks them.
module tb_operand_stream_feeder;

  localparam int RW    = 14;
  localparam int DEPTH = 1 << RW;

  typedef struct {
    logic [47:0] dat;
    bit          wd;
    bit          ad;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [3:0]    weight_count;
  logic [7:0]    activation_count;
  logic [RW-1:0] weight_base, act_base;
  logic          wram_en, aram_en;
  logic [RW-1:0] wram_addr, aram_addr;
  logic [23:0]   wram_rdata, aram_rdata;
  logic [47:0]   ram_data;
  logic          ram_valid, ram_ready;
  logic          weight_done, activation_done, busy;

  logic [23:0] wmem [DEPTH];
  logic [23:0] amem [DEPTH];

  exp_t  exp_q [$];
  int    errors = 0;
  int    checks = 0;
  int    n_words, n_wd, n_wen, n_aen;
  int    ready_mode = 0;
  bit    zero_win = 1'b0;
  bit    hold_prev = 1'b0;
  logic [47:0] prev_dat;

  operand_stream_feeder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .weight_count    (weight_count),
    .activation_count(activation_count),
    .weight_base     (weight_base),
    .act_base        (act_base),
    .wram_en         (wram_en),
    .wram_addr       (wram_addr),
    .wram_rdata      (wram_rdata),
    .aram_en         (aram_en),
    .aram_addr       (aram_addr),
    .aram_rdata      (aram_rdata),
    .ram_data        (ram_data),
    .ram_valid       (ram_valid),
    .ram_ready       (ram_ready),
    .weight_done     (weight_done),
    .activation_done (activation_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wram_en) wram_rdata <= wmem[wram_addr];
    if (aram_en) aram_rdata <= amem[aram_addr];
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: outer activation groups, inner weight groups, 4 lanes; missing lanes read as 0.
  task automatic model(input int w, input int a, input int wb, input int ab);
    int ngw = (w + 3) / 4;
    int nag = (a + 3) / 4;
    for (int ag = 0; ag < nag; ag++) begin
      for (int wg = 0; wg < ngw; wg++) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          logic [23:0] we, ae;
          we = '0;
          ae = '0;
          if (wg * 4 + k < w) we = wmem[(wb + wg * 4 + k) % DEPTH];
          if (ag * 4 + k < a) ae = amem[(ab + ag * 4 + k) % DEPTH];
          e.dat = {ae, we};
          e.wd  = (k == 3) && (wg == ngw - 1);
          e.ad  = e.wd && (ag == nag - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (wram_en) n_wen++;
      if (aram_en) n_aen++;
      if (weight_done) n_wd++;
      if (hold_prev) begin
        chk(ram_valid === 1'b1, "hold_valid", ram_valid, 1);
        chk(ram_data === prev_dat, "hold_data", ram_data, prev_dat);
      end
      if (ram_valid && ram_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_word", ram_data, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_words++;
          chk(ram_data === e.dat, "word_data", ram_data, e.dat);
          chk(weight_done === e.wd, "word_wdone", weight_done, e.wd);
          chk(activation_done === e.ad, "word_adone", activation_done, e.ad);
        end
      end else if ((weight_done || activation_done) && !zero_win) begin
        chk(1'b0, "stray_done", {weight_done, activation_done}, 0);
      end
      hold_prev = ram_valid && !ram_ready;
      prev_dat  = ram_data;
    end
  end

  initial begin
    ram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ram_ready = 1'b1;
        1:       ram_ready = ~ram_ready;
        default: ram_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_counts();
    n_words = 0;
    n_wd    = 0;
    n_wen   = 0;
    n_aen   = 0;
  endtask

  task automatic do_start(input int w, input int a, input int wb, input int ab);
    @(posedge clk);
    #1;
    weight_count     = 4'(w);
    activation_count = 8'(a);
    weight_base      = RW'(wb);
    act_base         = RW'(ab);
    start            = 1'b1;
    @(posedge clk);
    #1;
    start            = 1'b0;
    weight_count     = 4'($urandom);
    activation_count = 8'($urandom);
    weight_base      = RW'($urandom);
    act_base         = RW'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(exp_q.size() == 0, {tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_and_check(input string tag, input int w, input int a, input int wb, input int ab);
    clear_counts();
    model(w, a, wb, ab);
    do_start(w, a, wb, ab);
    wait_drain(tag);
    repeat (3) @(negedge clk);
    chk(n_words == 4 * ((w + 3) / 4) * ((a + 3) / 4), {tag, "_words"}, n_words, 4 * ((w + 3) / 4) * ((a + 3) / 4));
    chk(n_wd == (a + 3) / 4, {tag, "_wdone_cnt"}, n_wd, (a + 3) / 4);
    chk(n_wen == ((a + 3) / 4) * w, {tag, "_wram_reads"}, n_wen, ((a + 3) / 4) * w);
    chk(n_aen == ((w + 3) / 4) * a, {tag, "_aram_reads"}, n_aen, ((w + 3) / 4) * a);
    chk(busy === 1'b0, {tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int w, a, wb, ab;
    for (int i = 0; i < DEPTH; i++) begin
      wmem[i] = 24'($urandom);
      amem[i] = 24'($urandom);
    end
    reset_n = 1'b0;
    start = 1'b0;
    weight_count = '0;
    activation_count = '0;
    weight_base = '0;
    act_base = '0;
    clear_counts();
    repeat (2) @(negedge clk);
    chk(ram_valid === 1'b0, "rst_valid", ram_valid, 0);
    chk(wram_en === 1'b0 && aram_en === 1'b0, "rst_en", {wram_en, aram_en}, 0);
    chk(busy === 1'b0, "rst_busy", busy, 0);
    chk(weight_done === 1'b0 && activation_done === 1'b0, "rst_done", {weight_done, activation_done}, 0);
    chk(ram_data === 48'h0, "rst_data", ram_data, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // W=4, A=4 with latency probe
    ready_mode = 0;
    clear_counts();
    model(4, 4, 100, 200);
    do_start(4, 4, 100, 200);
    @(negedge clk);
    chk(wram_en === 1'b1 && aram_en === 1'b1, "lat_first_en", {wram_en, aram_en}, 3);
    chk(busy === 1'b1, "lat_busy", busy, 1);
    @(negedge clk);
    chk(ram_valid === 1'b0, "lat_valid_e1", ram_valid, 0);
    @(negedge clk);
    chk(ram_valid === 1'b1, "lat_valid_e2", ram_valid, 1);
    wait_drain("w4a4");
    @(negedge clk);
    chk(busy === 1'b0, "w4a4_busy_fall", busy, 0);
    chk(n_words == 4, "w4a4_words", n_words, 4);
    chk(n_wd == 1, "w4a4_wdone_cnt", n_wd, 1);

    run_and_check("w5a3", 5, 3, 16000, 300);

    ready_mode = 1;
    run_and_check("w4a8_toggle", 4, 8, 40, 50);

    // zero weight count: no reads, both done strobes one cycle after start
    ready_mode = 0;
    clear_counts();
    do_start(0, 7, 10, 20);
    zero_win = 1'b1;
    @(negedge clk);
    chk(weight_done === 1'b1, "zero_wdone", weight_done, 1);
    chk(activation_done === 1'b1, "zero_adone", activation_done, 1);
    #1 zero_win = 1'b0;
    @(negedge clk);
    chk(weight_done === 1'b0 && activation_done === 1'b0, "zero_pulse_len", {weight_done, activation_done}, 0);
    repeat (4) @(negedge clk);
    chk(n_wen == 0 && n_aen == 0, "zero_no_reads", n_wen + n_aen, 0);
    chk(n_words == 0, "zero_no_words", n_words, 0);

    // reset mid-run, then a clean restart
    ready_mode = 2;
    clear_counts();
    model(8, 8, 500, 600);
    do_start(8, 8, 500, 600);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk(ram_valid === 1'b0 && wram_en === 1'b0 && aram_en === 1'b0, "abort_outputs", {ram_valid, wram_en, aram_en}, 0);
    chk(busy === 1'b0 && weight_done === 1'b0 && activation_done === 1'b0, "abort_status", {busy, weight_done, activation_done}, 0);
    chk(ram_data === 48'h0, "abort_data", ram_data, 0);
    chk(n_wd == 0, "abort_no_wdone", n_wd, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_and_check("restart_w8a8", 8, 8, 700, 800);

    // start while busy with other counts is ignored
    clear_counts();
    model(6, 5, 1000, 2000);
    do_start(6, 5, 1000, 2000);
    repeat (3) @(posedge clk);
    #1;
    weight_count = 4'd2;
    activation_count = 8'd1;
    weight_base = RW'(9);
    act_base = RW'(9);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("restart_ignored");
    repeat (3) @(negedge clk);
    chk(n_words == 16, "restart_ignored_words", n_words, 16);
    chk(n_wd == 2, "restart_ignored_wdone", n_wd, 2);

    for (int t = 0; t < 5; t++) begin
      w  = $urandom_range(1, 15);
      a  = $urandom_range(1, 40);
      wb = (t % 2 == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      ab = (t % 2 == 1) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      run_and_check("rand", w, a, wb, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
